// File: rtl/result_checker.sv
// Table-driven result scoreboard: compares a sample stream against loaded expected values under per-entry masks.
// Counters, first-failure capture and verdict update on the edge that accepts a sample.
module result_checker #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              start,
    input  logic [IDX_W:0]    num_checks,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              first_fail_valid,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data,
    output logic              all_pass
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_N   = (IDX_W+1)'(1);

    state_t state, state_nx;

    logic [DATA_W-1:0] exp_mem  [DEPTH];
    logic [DATA_W-1:0] mask_mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   n_q;
    logic [IDX_W:0]   n_start;
    logic             start_ok;
    logic             take;
    logic             hit;
    logic             last;

    assign start_ok = start && (state != RUN);
    assign n_start  = (num_checks > DEPTH_N) ? DEPTH_N : num_checks;
    assign take     = (state == RUN) && sample_valid;
    assign hit      = ((sample_data ^ exp_mem[idx]) & mask_mem[idx]) == '0;
    assign last     = ({1'b0, idx} == (n_q - ONE_N));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (n_start == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (take && last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Table survives reset so a BIST pattern can be loaded once and rerun.
    always_ff @(posedge clk) begin
        if (cfg_we && (state != RUN)) begin
            exp_mem[cfg_addr]  <= cfg_data;
            mask_mem[cfg_addr] <= cfg_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx              <= '0;
            n_q              <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_data  <= '0;
            all_pass         <= 1'b0;
        end else if (start_ok) begin
            idx              <= '0;
            n_q              <= n_start;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_data  <= '0;
            all_pass         <= (n_start == '0);
        end else if (take) begin
            if (hit) begin
                if (pass_count != '1) begin
                    pass_count <= pass_count + 1'b1;
                end
            end else begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= idx;
                    first_fail_data  <= sample_data;
                end
            end
            // Saturation never returns fail_count to zero, so zero here means no prior failure.
            if (last) begin
                all_pass <= hit && (fail_count == '0);
            end
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker; a second instance with 2-bit counters shares all inputs.
module tb_result_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] cfg_mask;
    logic        start;
    logic [5:0]  num_checks;
    logic        sample_valid;
    logic [31:0] sample_data;

    logic        busy, done, first_fail_valid, all_pass;
    logic [7:0]  pass_count, fail_count;
    logic [4:0]  first_fail_idx;
    logic [31:0] first_fail_data;

    logic        sat_busy, sat_done, sat_ffv, sat_all_pass;
    logic [1:0]  sat_pass, sat_fail;
    logic [4:0]  sat_ffidx;
    logic [31:0] sat_ffdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] vals [20] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hb,
                               32'h3, 32'hfffffffe, 32'h0, 32'h5, 32'h1, 32'hfffffff4,
                               32'h4d2, 32'hfffff8d7, 32'h1, 32'hfffffb2c, 32'h30, 32'h30};

    always #5 clk = ~clk;

    result_checker #(.DATA_W(32), .DEPTH(32), .IDX_W(5), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask), .start(start), .num_checks(num_checks),
        .sample_valid(sample_valid), .sample_data(sample_data), .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data), .all_pass(all_pass)
    );

    result_checker #(.DATA_W(32), .DEPTH(32), .IDX_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask), .start(start), .num_checks(num_checks),
        .sample_valid(sample_valid), .sample_data(sample_data), .busy(sat_busy), .done(sat_done),
        .pass_count(sat_pass), .fail_count(sat_fail), .first_fail_valid(sat_ffv),
        .first_fail_idx(sat_ffidx), .first_fail_data(sat_ffdata), .all_pass(sat_all_pass)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_mask = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [5:0] n);
        start = 1'b1; num_checks = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        sample_valid = 1'b1; sample_data = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass_count), 0);
        chk({tag, "_fail"}, 32'(fail_count), 0);
        chk({tag, "_ffv"}, 32'(first_fail_valid), 0);
        chk({tag, "_ffidx"}, 32'(first_fail_idx), 0);
        chk({tag, "_ffdata"}, first_fail_data, 0);
        chk({tag, "_allpass"}, 32'(all_pass), 0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0;
        start = 1'b0; num_checks = '0; sample_valid = 1'b0; sample_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk_all_zero("reset");

        // Full matching stream of 20 samples.
        for (int i = 0; i < 20; i++) wr(5'(i), vals[i], 32'hffffffff);
        go(6'd20);
        chk("run_busy", 32'(busy), 1);
        for (int i = 0; i < 19; i++) send(vals[i]);
        chk("run_not_done_19", 32'(done), 0);
        send(vals[19]);
        chk("run_done", 32'(done), 1);
        chk("run_busy_low", 32'(busy), 0);
        chk("run_pass", 32'(pass_count), 20);
        chk("run_fail", 32'(fail_count), 0);
        chk("run_allpass", 32'(all_pass), 1);
        chk("run_ffv", 32'(first_fail_valid), 0);

        // Two injected mismatches.
        go(6'd20);
        chk("restart_clear_pass", 32'(pass_count), 0);
        chk("restart_done_low", 32'(done), 0);
        for (int i = 0; i < 20; i++)
            send(i == 9 ? 32'hfffffffd : (i == 15 ? 32'h0 : vals[i]));
        chk("mis_done", 32'(done), 1);
        chk("mis_fail", 32'(fail_count), 2);
        chk("mis_pass", 32'(pass_count), 18);
        chk("mis_ffv", 32'(first_fail_valid), 1);
        chk("mis_ffidx", 32'(first_fail_idx), 9);
        chk("mis_ffdata", first_fail_data, 32'hfffffffd);
        chk("mis_allpass", 32'(all_pass), 0);

        // Partial mask on entry 0.
        wr(5'd0, 32'h1234abcd, 32'h0000ffff);
        vals[0] = 32'h1234abcd;
        go(6'd1);
        send(32'hffffabcd);
        chk("mask_pass", 32'(pass_count), 1);
        chk("mask_allpass", 32'(all_pass), 1);
        go(6'd1);
        send(32'h1234abce);
        chk("mask_fail", 32'(fail_count), 1);
        chk("mask_fail_allpass", 32'(all_pass), 0);

        // Gapped samples; mid-run start and cfg_we must be ignored.
        go(6'd3);
        send(32'hffffabcd);
        start = 1'b1; num_checks = 6'd1; tick(); start = 1'b0;
        wr(5'd1, 32'h55, 32'hffffffff);
        send(32'h1);
        chk("gap_busy", 32'(busy), 1);
        tick(); tick();
        chk("gap_not_done", 32'(done), 0);
        chk("gap_pass2", 32'(pass_count), 2);
        send(32'h2);
        chk("gap_done", 32'(done), 1);
        chk("gap_pass", 32'(pass_count), 3);
        chk("gap_fail", 32'(fail_count), 0);
        go(6'd2);
        send(32'hffffabcd);
        send(32'h1);
        chk("table_kept_pass", 32'(pass_count), 2);
        chk("table_kept_allpass", 32'(all_pass), 1);

        // Zero-length run.
        go(6'd0);
        chk("n0_done", 32'(done), 1);
        chk("n0_allpass", 32'(all_pass), 1);
        chk("n0_busy", 32'(busy), 0);

        // Reset mid-run, idle samples ignored, start beats a simultaneous sample.
        go(6'd10);
        for (int i = 0; i < 5; i++) send(vals[i]);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all_zero("midreset");
        send(32'hdeadbeef);
        chk("idle_sample_pass", 32'(pass_count), 0);
        chk("idle_sample_fail", 32'(fail_count), 0);
        sample_valid = 1'b1; sample_data = 32'hdeadbeef;
        go(6'd10);
        sample_valid = 1'b0;
        chk("start_wins_fail", 32'(fail_count), 0);
        for (int i = 0; i < 10; i++) send(vals[i]);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_pass", 32'(pass_count), 10);
        chk("rerun_allpass", 32'(all_pass), 1);

        // Counter saturation on the 2-bit instance.
        go(6'd6);
        for (int i = 0; i < 5; i++) send(vals[i] ^ 32'h1);
        chk("sat_not_done", 32'(sat_done), 0);
        send(vals[5] ^ 32'h1);
        chk("sat_done", 32'(sat_done), 1);
        chk("sat_fail", 32'(sat_fail), 3);
        chk("sat_pass", 32'(sat_pass), 0);
        chk("sat_ffidx", 32'(sat_ffidx), 0);
        chk("sat_allpass", 32'(sat_all_pass), 0);
        chk("wide_fail", 32'(fail_count), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
